// File: rtl/hrv_pkg.sv
// Shared types and constants for the HRV front-end sequencer.
package hrv_pkg;

  localparam int unsigned WINDOW = 8;
  localparam int unsigned RR_W   = 8;
  localparam int unsigned RR_SAT = 255;

  typedef logic [RR_W-1:0] rr_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_KICK,
    ST_STREAM,
    ST_WAIT,
    ST_REPORT
  } seq_state_t;

endpackage

// File: rtl/hrv_rr_fifo.sv
// Circular buffer holding accepted RR intervals until a full window is ready.
module hrv_rr_fifo
  import hrv_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  rr_t                    wr_data,
  output rr_t                    rd_data_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  rr_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full_c    = (count == CW'(DEPTH));
  assign empty_c   = (count == '0);
  assign do_pop    = pop && !empty_c;
  // A simultaneous pop frees a slot, so a push alongside it is kept even when full.
  assign do_push   = push && (!full_c || do_pop);
  assign rd_data_c = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/hrv_window_sequencer.sv
// Times RR intervals, buffers accepted ones and drives the RMSSD engine one window at a time.
module hrv_window_sequencer
  import hrv_pkg::*;
#(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MIN_RR  = 20,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            tick,
  input  logic            beat,
  output logic            eng_rst_n,
  output logic            eng_valid,
  output logic [RR_W-1:0] eng_rr,
  input  logic            eng_done,
  input  logic [RR_W-1:0] eng_rmssd,
  output logic [RR_W-1:0] rmssd,
  output logic            result_valid,
  output logic [7:0]      rej_count,
  output logic            err_overflow,
  output logic            err_timeout
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = $clog2(WINDOW);

  seq_state_t      state;
  logic [RR_W-1:0] tick_cnt;
  logic [RR_W-1:0] interval_c;
  logic            armed;
  logic            reject_c;
  logic            push_c;
  logic            pop_c;
  logic            full_c;
  logic            empty_c;
  rr_t             head_c;
  logic [CW-1:0]   count;
  logic [SW-1:0]   stream_idx;
  logic [TW-1:0]   wait_cnt;

  // Tick in the same cycle as a beat is counted before the beat samples the counter.
  always_comb begin
    interval_c = tick_cnt;
    if (tick && (tick_cnt != RR_W'(RR_SAT))) interval_c = tick_cnt + RR_W'(1);
  end

  assign reject_c = (interval_c < RR_W'(MIN_RR)) || (interval_c == RR_W'(RR_SAT));
  assign push_c   = beat && armed && !reject_c;
  // Pop in KICK and in the first seven STREAM cycles so each STREAM cycle shows a fresh entry.
  assign pop_c    = !empty_c && ((state == ST_KICK) ||
                    ((state == ST_STREAM) && (stream_idx != SW'(WINDOW - 1))));

  hrv_rr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_c),
    .pop       (pop_c),
    .wr_data   (interval_c),
    .rd_data_c (head_c),
    .count     (count),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  // Interval timer, rejection counter and overflow flag; runs in every FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt     <= '0;
      armed        <= 1'b0;
      rej_count    <= '0;
      err_overflow <= 1'b0;
    end else begin
      tick_cnt <= beat ? '0 : interval_c;
      if (beat) armed <= 1'b1;
      if (beat && armed && reject_c && (rej_count != 8'd255)) rej_count <= rej_count + 8'd1;
      if (push_c && full_c && !pop_c) err_overflow <= 1'b1;
    end
  end

  // Window sequencer with registered engine controls and result publishing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      eng_rst_n    <= 1'b0;
      eng_valid    <= 1'b0;
      eng_rr       <= '0;
      rmssd        <= '0;
      result_valid <= 1'b0;
      err_timeout  <= 1'b0;
      stream_idx   <= '0;
      wait_cnt     <= '0;
    end else begin
      eng_rst_n    <= 1'b1;
      eng_valid    <= 1'b0;
      result_valid <= 1'b0;
      if (pop_c) eng_rr <= head_c;
      case (state)
        ST_IDLE: begin
          if (count >= CW'(WINDOW)) begin
            state     <= ST_CLEAR;
            eng_rst_n <= 1'b0;
          end
        end
        ST_CLEAR: begin
          state     <= ST_KICK;
          eng_valid <= 1'b1;
        end
        ST_KICK: begin
          state      <= ST_STREAM;
          stream_idx <= '0;
        end
        ST_STREAM: begin
          if (stream_idx == SW'(WINDOW - 1)) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end else begin
            stream_idx <= stream_idx + SW'(1);
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            state        <= ST_REPORT;
            rmssd        <= eng_rmssd;
            result_valid <= 1'b1;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state       <= ST_IDLE;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + TW'(1);
          end
        end
        ST_REPORT: state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hrv_window_sequencer.sv
// Directed bench for hrv_window_sequencer with a behavioural RMSSD engine and a scoreboard.
module tb_hrv_window_sequencer;
  import hrv_pkg::*;

  localparam int MIN_RR = 20;

  logic       clk;
  logic       rst;
  logic       tick;
  logic       beat;
  logic       eng_rst_n;
  logic       eng_valid;
  logic [7:0] eng_rr;
  logic       eng_done;
  logic [7:0] eng_rmssd;
  logic [7:0] rmssd;
  logic       result_valid;
  logic [7:0] rej_count;
  logic       err_overflow;
  logic       err_timeout;

  // Second instance with a long timeout, used only to fill its FIFO.
  logic       beat_o;
  logic       o_eng_rst_n;
  logic       o_eng_valid;
  logic [7:0] o_eng_rr;
  logic       o_eng_done;
  logic [7:0] o_eng_rmssd;
  logic [7:0] o_rmssd;
  logic       o_result_valid;
  logic [7:0] o_rej_count;
  logic       o_err_overflow;
  logic       o_err_timeout;

  assign o_eng_done  = 1'b0;
  assign o_eng_rmssd = 8'd0;

  hrv_window_sequencer #(.DEPTH(16), .MIN_RR(MIN_RR), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .beat(beat),
    .eng_rst_n(eng_rst_n), .eng_valid(eng_valid), .eng_rr(eng_rr),
    .eng_done(eng_done), .eng_rmssd(eng_rmssd), .rmssd(rmssd),
    .result_valid(result_valid), .rej_count(rej_count),
    .err_overflow(err_overflow), .err_timeout(err_timeout)
  );

  hrv_window_sequencer #(.DEPTH(16), .MIN_RR(MIN_RR), .TIMEOUT(1000)) u_ovf (
    .clk(clk), .rst(rst), .tick(tick), .beat(beat_o),
    .eng_rst_n(o_eng_rst_n), .eng_valid(o_eng_valid), .eng_rr(o_eng_rr),
    .eng_done(o_eng_done), .eng_rmssd(o_eng_rmssd), .rmssd(o_rmssd),
    .result_valid(o_result_valid), .rej_count(o_rej_count),
    .err_overflow(o_err_overflow), .err_timeout(o_err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int rr_q[$];
  int rmssd_q[$];
  int win[$];
  bit armed;
  int exp_rej;
  bit stub;
  int windows = 0;
  int results = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int rmssd_calc(input int s[$]);
    int acc = 0;
    int r   = 0;
    for (int i = 1; i < s.size(); i++) acc += (s[i] - s[i-1]) * (s[i] - s[i-1]);
    acc = acc >> 3;
    while ((r + 1) * (r + 1) <= acc) r++;
    return r;
  endfunction

  // Behavioural engine: kicked by eng_valid, samples 8 values, raises done two cycles later.
  int eq[$];
  int ph;
  always @(posedge clk or negedge eng_rst_n) begin
    if (!eng_rst_n) begin
      eng_done  <= 1'b0;
      eng_rmssd <= 8'd0;
      ph        <= 0;
    end else if (eng_valid) begin
      eq.delete();
      ph <= 1;
    end else if (ph >= 1 && ph <= 8) begin
      eq.push_back(int'(eng_rr));
      ph <= ph + 1;
    end else if (ph == 9) begin
      ph <= 10;
    end else if (ph == 10) begin
      ph <= 0;
      if (!stub) begin
        eng_done  <= 1'b1;
        eng_rmssd <= 8'(rmssd_calc(eq));
      end
    end
  end

  // Output monitor: checks streamed samples, handshake ordering, latencies and results.
  int  cyc = 0;
  int  valid_cyc = 0;
  int  stream_left = 0;
  logic prev_rst_n = 1'b0;
  logic prev_tmo = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stream_left = 0;
      prev_tmo    = 1'b0;
      prev_rst_n  = 1'b0;
      rr_q.delete();
      rmssd_q.delete();
    end else begin
      if (stream_left > 0) begin
        chk("rr_expected", int'(rr_q.size() > 0), 1);
        if (rr_q.size() > 0) chk("eng_rr", int'(eng_rr), rr_q.pop_front());
        stream_left--;
      end
      if (eng_valid) begin
        chk("clear_before_kick", int'(prev_rst_n), 0);
        stream_left = 8;
        valid_cyc   = cyc;
        windows++;
      end
      if (result_valid) begin
        results++;
        chk("report_latency", cyc - valid_cyc, 12);
        chk("result_expected", int'(rmssd_q.size() > 0), 1);
        if (rmssd_q.size() > 0) chk("rmssd", int'(rmssd), rmssd_q.pop_front());
      end
      if (err_timeout && !prev_tmo) chk("timeout_latency", cyc - valid_cyc, 17);
      prev_tmo   = err_timeout;
      prev_rst_n = eng_rst_n;
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pair();
    tick = 1'b1; step();
    tick = 1'b0; step();
  endtask

  // Interval of n ticks ending in a beat; co puts the last tick in the beat cycle.
  task automatic interval(input int n, input bit co);
    int v;
    v = (n > 255) ? 255 : n;
    if (co) begin
      repeat (n - 1) tick_pair();
      tick = 1'b1; beat = 1'b1; step();
      tick = 1'b0; beat = 1'b0;
    end else begin
      repeat (n) tick_pair();
      beat = 1'b1; step();
      beat = 1'b0;
    end
    if (!armed) begin
      armed = 1'b1;
    end else if (v < MIN_RR || v == 255) begin
      exp_rej = (exp_rej == 255) ? 255 : exp_rej + 1;
    end else begin
      rr_q.push_back(v);
      win.push_back(v);
      if (win.size() == 8) begin
        if (!stub) rmssd_q.push_back(rmssd_calc(win));
        win.delete();
      end
    end
  endtask

  task automatic interval_o(input int n);
    repeat (n) tick_pair();
    beat_o = 1'b1; step();
    beat_o = 1'b0;
  endtask

  task automatic wait_results(input int target, input int budget);
    int k = 0;
    while (results < target && k < budget) begin step(); k++; end
    chk("result_wait", results, target);
  endtask

  task automatic check_reset_values(input string pfx);
    chk({pfx, "_eng_rst_n"}, int'(eng_rst_n), 0);
    chk({pfx, "_eng_valid"}, int'(eng_valid), 0);
    chk({pfx, "_eng_rr"}, int'(eng_rr), 0);
    chk({pfx, "_rmssd"}, int'(rmssd), 0);
    chk({pfx, "_result_valid"}, int'(result_valid), 0);
    chk({pfx, "_rej_count"}, int'(rej_count), 0);
    chk({pfx, "_err_overflow"}, int'(err_overflow), 0);
    chk({pfx, "_err_timeout"}, int'(err_timeout), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int w_snap;
    int r_snap;
    rst = 1'b1; tick = 1'b0; beat = 1'b0; beat_o = 1'b0;
    stub = 1'b0; armed = 1'b0; exp_rej = 0;
    repeat (3) step();
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Arming beat (short gap, must not count as a reject), then eight 100-tick intervals.
    interval(5, 1'b0);
    repeat (8) interval(100, 1'b0);
    wait_results(1, 100);
    chk("rej_after_arm", int'(rej_count), exp_rej);

    // Alternating 100/110, with tick and beat coinciding on the 110 intervals.
    for (int i = 0; i < 8; i++) interval((i % 2) ? 110 : 100, (i % 2) == 1);
    wait_results(2, 100);

    // Rejections: too short, saturated, and just below MIN_RR; MIN_RR itself and 254 accepted.
    interval(10, 1'b0);
    interval(300, 1'b1);
    step();
    chk("rej_short_and_sat", int'(rej_count), exp_rej);
    interval(MIN_RR - 1, 1'b0);
    step();
    chk("rej_below_min", int'(rej_count), exp_rej);
    chk("no_overflow", int'(err_overflow), 0);

    // Engine that never completes: window must time out without publishing.
    stub = 1'b1;
    interval(MIN_RR, 1'b1);
    interval(254, 1'b0);
    repeat (6) interval(50, 1'b0);
    k = 0;
    while (!err_timeout && k < 300) begin step(); k++; end
    chk("err_timeout", int'(err_timeout), 1);
    chk("no_result_on_timeout", results, 2);
    stub = 1'b0;

    // Sequencer must be back in IDLE with the timed-out window fully consumed.
    for (int i = 0; i < 8; i++) interval((i % 2) ? 33 : 30, 1'b0);
    wait_results(3, 100);
    chk("rej_stable", int'(rej_count), exp_rej);

    // Reset in the middle of STREAM.
    w_snap = windows;
    for (int i = 0; i < 8; i++) interval((i % 2) ? 44 : 40, 1'b0);
    k = 0;
    while (windows == w_snap && k < 100) begin step(); k++; end
    chk("window_started", windows, w_snap + 1);
    repeat (2) step();
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    step(); step();
    rst = 1'b0;
    armed = 1'b0;
    exp_rej = 0;
    win.delete();
    step();

    // After reset the first beat only arms: seven intervals must not start a window.
    w_snap = windows;
    r_snap = results;
    for (int i = 0; i < 8; i++) interval((i % 2) ? 44 : 40, 1'b0);
    repeat (60) step();
    chk("no_window_with_7", windows, w_snap);
    chk("no_result_after_reset", results, r_snap);
    interval(40, 1'b0);
    wait_results(r_snap + 1, 100);

    // Overflow on the long-timeout instance: 8 drained, then 16 fill, the 17th is dropped.
    interval_o(30);
    repeat (24) interval_o(20);
    step();
    chk("ovf_not_yet", int'(o_err_overflow), 0);
    interval_o(20);
    step();
    chk("ovf_set", int'(o_err_overflow), 1);
    chk("main_no_overflow", int'(err_overflow), 0);

    chk("rr_q_drained", rr_q.size(), 0);
    chk("rmssd_q_drained", rmssd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hrv_window_sequencer.md
# hrv_window_sequencer

Front-end controller for the RMSSD engine in the HRV design. It times beat-to-beat (RR) intervals from a beat-detector pulse and a millisecond tick, and rejects out-of-range intervals. It buffers accepted intervals, then sequences the engine through one 8-interval window at a time. For each window it resets the engine, kicks it, streams the samples, waits for `done` and publishes the result.

## Interface
Parameters:
- `DEPTH`, 16: interval FIFO entries (power of two, ≥ 8).
- `MIN_RR`, 20: smallest accepted interval in ticks; smaller values are rejected.
- `TIMEOUT`, 8: cycles allowed in WAIT for engine `done`.

Ports:
- `clk`  in  1  single clock for the whole block.
- `rst`  in  1  reset: asynchronous, active-high.
- `tick`  in  1  1 ms strobe, one cycle wide.
- `beat`  in  1  beat-detected strobe, one cycle wide.
- `eng_rst_n`  out  1  registered active-low reset to the engine.
- `eng_valid`  out  1  engine start strobe.
- `eng_rr`  out  8  sample presented to the engine.
- `eng_done`  in  1  engine done (sticky until engine reset).
- `eng_rmssd`  in  8  engine result.
- `rmssd`  out  8  last published result.
- `result_valid`  out  1  one-cycle publish strobe.
- `rej_count`  out  8  rejected intervals, saturating at 255.
- `err_overflow`  out  1  sticky; set when an accepted interval is dropped because the FIFO is full.
- `err_timeout`  out  1  sticky; set when WAIT expires.

## Operation
Interval timer:
- 8-bit tick counter, saturating at 255.
- If `tick` and `beat` occur in the same cycle, the tick counts before the beat samples the counter.
- On `beat`, the counter value is the interval and the counter clears to 0.
- The first `beat` after reset only arms the timer; no interval is produced.
- An interval is rejected (`rej_count`+1, not pushed) when it is `< MIN_RR` or `== 255`. All other intervals are pushed.

FIFO:
- Circular buffer, `DEPTH` entries.
- Push and pop in the same cycle are legal; occupancy is unchanged.
- A push while full is dropped and sets `err_overflow`.

FSM states, in order: IDLE → CLEAR → KICK → STREAM → WAIT → REPORT → IDLE.
- IDLE: when occupancy ≥ 8, go to CLEAR.
- CLEAR, 1 cycle: `eng_rst_n`=0.
- KICK, 1 cycle: `eng_valid`=1. `eng_rr` is don't-care.
- STREAM, exactly 8 cycles: present the oldest entry on `eng_rr` and pop one entry per cycle.
- WAIT: exit when `eng_done`=1, or after `TIMEOUT` cycles. On timeout, set `err_timeout` and return to IDLE without publishing.
- REPORT, 1 cycle: `rmssd` ← `eng_rmssd`, `result_valid`=1.

Other rules:
- Windows do not overlap.
- Interval capture continues in every state.
- `eng_rr` holds its last value outside STREAM.

Reset values while `rst` is high:
- `eng_rst_n`=0.
- `eng_valid`, `eng_rr`, `rmssd`, `result_valid`, `rej_count`, `err_overflow`, `err_timeout` = 0.
- FIFO empty, timer disarmed, state IDLE.

Reset mid-window: the partial window is discarded and nothing is published afterwards.

## Timing
- Let IDLE observe occupancy ≥ 8 in cycle t. Then:
  - t+1: CLEAR.
  - t+2: KICK.
  - t+3..t+10: STREAM.
  - WAIT is entered at t+11.
- A conforming engine raises `eng_done` at t+13, so REPORT occurs at t+14 and `result_valid` is high in t+14.
- Occupancy used by IDLE is registered, so a push in cycle t is visible from t+1.
- All outputs are registered. `eng_rst_n` must be glitch-free because it drives an asynchronous reset.
- Best-case window period is 14 cycles. Beats are ≥ `MIN_RR` ms apart, so the FIFO cannot overflow while the engine responds within `TIMEOUT`.

## Structure
- Package `hrv_pkg`:
  - state enum `seq_state_t`;
  - `WINDOW`=8;
  - `RR_W`=8;
  - `RR_SAT`=255.
- Sub-module `hrv_rr_fifo`: circular buffer with push/pop, occupancy, full and empty.
- Timer, rejection logic and FSM live in the top level.

## Test plan
- Eight beats 100 ticks apart (after an arming beat), real engine connected → `eng_rr` = 100 for all 8 STREAM cycles; `result_valid` at t+14 with `rmssd`=0.
- Intervals alternating 100/110 ×8 → `rmssd`=9 (sum of squared differences 700, >>3 = 87, square root 9).
- One interval of 10 ticks, then one with no beat for 300 ticks → `rej_count`=2; FIFO occupancy unchanged.
- Stub engine never raises `eng_done` → `err_timeout`=1 after 8 WAIT cycles; no `result_valid`; FSM back in IDLE with 8 entries popped.
- Stall with the stub engine while pushing 17 intervals → `err_overflow`=1; occupancy stays at 16.
- Assert `rst` during STREAM → all outputs at reset values in the same cycle (asynchronous); no `result_valid` afterwards until a fresh arming beat plus 8 new intervals.
